// File: rtl/spi_ram_burst.sv
// SPI-slave memory back end: decodes 2-bit-opcode command words, keeps separate
// write/read pointers with optional burst increment, returns read data over valid/ready.
module spi_ram_burst #(
    parameter int DATA_W    = 8,
    parameter int ADDR_W    = 8,
    parameter int MEM_DEPTH = 256,
    parameter int AUTO_INC  = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx_valid,
    output logic              rx_ready,
    input  logic [DATA_W+1:0] din,
    output logic [DATA_W-1:0] dout,
    output logic              tx_valid,
    input  logic              tx_ready,
    output logic              addr_err
);
    typedef enum logic {IDLE, TX} state_t;

    localparam logic [1:0] OP_WR_ADDR = 2'b00;
    localparam logic [1:0] OP_WR_DATA = 2'b01;
    localparam logic [1:0] OP_RD_ADDR = 2'b10;
    localparam logic [1:0] OP_RD_DATA = 2'b11;

    function automatic logic in_range(input logic [ADDR_W-1:0] p);
        return int'(32'(p)) < MEM_DEPTH;
    endfunction

    // Wrap at the last implemented word, not at 2**ADDR_W.
    function automatic logic [ADDR_W-1:0] inc_ptr(input logic [ADDR_W-1:0] p);
        if (AUTO_INC == 0)
            return p;
        if (int'(32'(p)) == MEM_DEPTH - 1)
            return '0;
        return p + ADDR_W'(1);
    endfunction

    logic [DATA_W-1:0] mem [MEM_DEPTH];

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [DATA_W-1:0] dout_q, dout_d;
    logic              tx_valid_q, tx_valid_d;
    logic              addr_err_q, addr_err_d;
    logic              accept;
    logic              mem_we;
    logic [1:0]        opcode;
    logic [DATA_W-1:0] payload;
    logic [DATA_W-1:0] rd_data;

    assign opcode   = din[DATA_W+1:DATA_W];
    assign payload  = din[DATA_W-1:0];
    assign rx_ready = (state_q == IDLE);
    assign accept   = rx_valid & rx_ready;
    assign rd_data  = in_range(rd_ptr_q) ? mem[rd_ptr_q] : '0;

    always_comb begin
        state_d    = state_q;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        dout_d     = dout_q;
        tx_valid_d = tx_valid_q;
        addr_err_d = addr_err_q;
        mem_we     = 1'b0;
        case (state_q)
            IDLE: begin
                tx_valid_d = 1'b0;
                if (accept) begin
                    case (opcode)
                        OP_WR_ADDR: wr_ptr_d = payload[ADDR_W-1:0];
                        OP_WR_DATA: begin
                            if (in_range(wr_ptr_q))
                                mem_we = 1'b1;
                            else
                                addr_err_d = 1'b1;
                            wr_ptr_d = inc_ptr(wr_ptr_q);
                        end
                        OP_RD_ADDR: rd_ptr_d = payload[ADDR_W-1:0];
                        OP_RD_DATA: begin
                            if (!in_range(rd_ptr_q))
                                addr_err_d = 1'b1;
                            dout_d     = rd_data;
                            tx_valid_d = 1'b1;
                            state_d    = TX;
                            rd_ptr_d   = inc_ptr(rd_ptr_q);
                        end
                        default: ;
                    endcase
                end
            end
            TX: begin
                if (tx_ready) begin
                    tx_valid_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            dout_q     <= '0;
            tx_valid_q <= 1'b0;
            addr_err_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            dout_q     <= dout_d;
            tx_valid_q <= tx_valid_d;
            addr_err_q <= addr_err_d;
        end
    end

    // Array contents survive reset; only the write is suppressed while rst is high.
    always_ff @(posedge clk) begin
        if (mem_we && !rst)
            mem[wr_ptr_q] <= payload;
    end

    assign dout     = dout_q;
    assign tx_valid = tx_valid_q;
    assign addr_err = addr_err_q;
endmodule

// File: tb/tb_spi_ram_burst.sv
// Directed bench: three builds (default, MEM_DEPTH=200, AUTO_INC=0) driven from one sequence.
module tb_spi_ram_burst;
    logic       clk = 1'b0;
    logic       rst;
    logic       rx_valid [3];
    logic       rx_ready [3];
    logic [9:0] din      [3];
    logic [7:0] dout     [3];
    logic       tx_valid [3];
    logic       tx_ready [3];
    logic       addr_err [3];

    int n_chk  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(1)) u_dut (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[0]), .rx_ready(rx_ready[0]), .din(din[0]),
        .dout(dout[0]), .tx_valid(tx_valid[0]), .tx_ready(tx_ready[0]), .addr_err(addr_err[0]));

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(200), .AUTO_INC(1)) u_d200 (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[1]), .rx_ready(rx_ready[1]), .din(din[1]),
        .dout(dout[1]), .tx_valid(tx_valid[1]), .tx_ready(tx_ready[1]), .addr_err(addr_err[1]));

    spi_ram_burst #(.DATA_W(8), .ADDR_W(8), .MEM_DEPTH(256), .AUTO_INC(0)) u_noinc (
        .clk(clk), .rst(rst), .rx_valid(rx_valid[2]), .rx_ready(rx_ready[2]), .din(din[2]),
        .dout(dout[2]), .tx_valid(tx_valid[2]), .tx_ready(tx_ready[2]), .addr_err(addr_err[2]));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int d, input logic [1:0] op, input logic [7:0] pl);
        rx_valid[d] = 1'b1;
        din[d]      = {op, pl};
        tick();
        rx_valid[d] = 1'b0;
    endtask

    task automatic rd(input int d, input logic [7:0] exp, input string tag);
        send(d, 2'b11, 8'h00);
        chk({tag, "_vld"}, 32'(tx_valid[d]), 32'd1);
        chk({tag, "_dout"}, 32'(dout[d]), 32'(exp));
        tx_ready[d] = 1'b1;
        tick();
        tx_ready[d] = 1'b0;
        chk({tag, "_done"}, 32'(tx_valid[d]), 32'd0);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 3; i++) begin
            rx_valid[i] = 1'b0;
            din[i]      = '0;
            tx_ready[i] = 1'b0;
        end
        do_reset();

        // reset state of every build
        for (int i = 0; i < 3; i++) begin
            chk($sformatf("rst_dout%0d", i), 32'(dout[i]), 32'd0);
            chk($sformatf("rst_vld%0d", i), 32'(tx_valid[i]), 32'd0);
            chk($sformatf("rst_err%0d", i), 32'(addr_err[i]), 32'd0);
            chk($sformatf("rst_rdy%0d", i), 32'(rx_ready[i]), 32'd1);
        end

        // first read of address 0 after a write, pointers start at 0
        send(0, 2'b01, 8'h3C);
        rd(0, 8'h3C, "t1_rd0");

        // write burst, read burst; tx_ready held high while idle is ignored
        send(0, 2'b00, 8'h10);
        send(0, 2'b01, 8'hA1);
        send(0, 2'b01, 8'hA2);
        send(0, 2'b01, 8'hA3);
        tx_ready[0] = 1'b1;
        send(0, 2'b10, 8'h10);
        chk("t2_idle_vld", 32'(tx_valid[0]), 32'd0);
        tx_ready[0] = 1'b0;
        rd(0, 8'hA1, "t2_b0");
        rd(0, 8'hA2, "t2_b1");
        rd(0, 8'hA3, "t2_b2");

        // backpressure: held RD_ADDR 0x12 must wait out the TX phase, not be dropped
        send(0, 2'b10, 8'h10);
        send(0, 2'b11, 8'h00);
        rx_valid[0] = 1'b1;
        din[0]      = {2'b10, 8'h12};
        for (int c = 0; c < 5; c++) begin
            chk($sformatf("t3_vld_c%0d", c), 32'(tx_valid[0]), 32'd1);
            chk($sformatf("t3_dout_c%0d", c), 32'(dout[0]), 32'hA1);
            chk($sformatf("t3_rdy_c%0d", c), 32'(rx_ready[0]), 32'd0);
            tick();
        end
        tx_ready[0] = 1'b1;
        tick();
        tx_ready[0] = 1'b0;
        chk("t3_vld_drop", 32'(tx_valid[0]), 32'd0);
        chk("t3_rdy_back", 32'(rx_ready[0]), 32'd1);
        tick();
        rx_valid[0] = 1'b0;
        rd(0, 8'hA3, "t3_held");

        // natural wrap at 0xFF on both pointers
        send(0, 2'b00, 8'hFF);
        send(0, 2'b01, 8'h11);
        send(0, 2'b01, 8'h22);
        send(0, 2'b10, 8'hFF);
        rd(0, 8'h11, "t4_ff");
        rd(0, 8'h22, "t4_00");
        chk("t4_err", 32'(addr_err[0]), 32'd0);

        // MEM_DEPTH=200: wrap at 199, then an out-of-range access
        send(1, 2'b00, 8'hC7);
        send(1, 2'b01, 8'h77);
        send(1, 2'b01, 8'h78);
        send(1, 2'b10, 8'hC7);
        rd(1, 8'h77, "t5_c7");
        rd(1, 8'h78, "t5_wrap0");
        chk("t5_err_pre", 32'(addr_err[1]), 32'd0);
        send(1, 2'b00, 8'hC8);
        send(1, 2'b01, 8'h55);
        chk("t5_err_wr", 32'(addr_err[1]), 32'd1);
        send(1, 2'b10, 8'hC8);
        rd(1, 8'h00, "t5_oor");
        send(1, 2'b10, 8'h00);
        rd(1, 8'h78, "t5_after");
        chk("t5_err_sticky", 32'(addr_err[1]), 32'd1);

        // AUTO_INC=0: pointers never move
        send(2, 2'b00, 8'h05);
        send(2, 2'b01, 8'h33);
        send(2, 2'b01, 8'h44);
        send(2, 2'b10, 8'h05);
        rd(2, 8'h44, "t6_same0");
        rd(2, 8'h44, "t6_same1");

        // reset while in TX
        send(0, 2'b10, 8'h10);
        send(0, 2'b11, 8'h00);
        chk("t6_in_tx", 32'(rx_ready[0]), 32'd0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("t6_rst_vld", 32'(tx_valid[0]), 32'd0);
        chk("t6_rst_rdy", 32'(rx_ready[0]), 32'd1);
        chk("t6_rst_dout", 32'(dout[0]), 32'd0);
        chk("t6_rst_err1", 32'(addr_err[1]), 32'd0);
        send(0, 2'b01, 8'h5A);
        rd(0, 8'h5A, "t6_ptr0");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
